// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control unit for the multicycle RV32I core. It steps each instruction
//   through FETCH, DECODE, EXEC, MEM and WB, sharing one ALU and one memory
//   port, and drives the immediate generator select (ext_op).
//
// Configuration macro:
//   MCTRL_EBREAK_EN - when defined, EBREAK (32'h0010_0073) halts cleanly
//                     (halted=1, illegal=0, counted as retired). When
//                     undefined, every SYSTEM encoding is illegal.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr           current IR contents
//   mem_ready       memory finishes the current access this cycle
//   br_taken        ALU compare result for the current branch
//   mem_req/mem_we  memory request and its write qualifier
//   ir_we           load IR from memory and OLDPC from PC
//   pc_we, pc_sel   PC write enable / source (00 PC+4, 01 OLDPC+Imm, 10 ALU)
//   ext_op          immediate select (I=000 U=001 S=010 B=011 J=100)
//   alu_a_sel       ALU A source (00 rs1, 01 OLDPC, 10 zero)
//   alu_b_sel       ALU B source (0 rs2, 1 Imm)
//   alu_func        {sub/sra bit, funct3}
//   reg_we, wb_sel  register write enable / source (00 ALU, 01 mem, 10 PC+4)
//   illegal, halted sticky status flags
//   state           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//   instr_cnt       retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       ext_op,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [3:0]       alu_func,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

`ifdef MCTRL_EBREAK_EN
  localparam bit EBREAK_EN = 1'b1;
`else
  localparam bit EBREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_LUI, C_AUIPC, C_EBREAK, C_ILL
  } cls_t;

  state_t           r_state;
  cls_t             r_cls;
  logic [2:0]       r_ext_op;
  logic [1:0]       r_alu_a_sel;
  logic             r_alu_b_sel;
  logic [3:0]       r_alu_func;
  logic [1:0]       r_wb_sel;
  logic             r_illegal;
  logic             r_halted;
  logic [CNT_W-1:0] r_instr_cnt;

  cls_t             w_cls;
  logic [2:0]       w_ext_op;
  logic [1:0]       w_alu_a_sel;
  logic             w_alu_b_sel;
  logic [3:0]       w_alu_func;
  logic [1:0]       w_wb_sel;
  logic [2:0]       w_funct3;
  logic             w_rd_nz;

  assign w_funct3 = instr[14:12];
  assign w_rd_nz  = (instr[11:7] != 5'd0);

  // Opcode decode, registered only in DECODE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_cls       = C_ILL;
    w_ext_op    = 3'b000;
    w_alu_a_sel = 2'b00;
    w_alu_b_sel = 1'b0;
    w_alu_func  = 4'b0000;
    w_wb_sel    = 2'b00;
    unique case (instr[6:0])
      7'b0110011: begin
        w_cls      = C_OP;
        w_alu_func = {instr[30], w_funct3};
      end
      7'b0010011: begin
        w_cls       = C_OPIMM;
        w_alu_b_sel = 1'b1;
        // Only the shift-right pair uses bit 30 (srli vs srai).
        w_alu_func  = {(w_funct3 == 3'b101) ? instr[30] : 1'b0, w_funct3};
      end
      7'b0000011: begin
        w_cls       = C_LOAD;
        w_alu_b_sel = 1'b1;
        w_wb_sel    = 2'b01;
      end
      7'b0100011: begin
        w_cls       = C_STORE;
        w_ext_op    = 3'b010;
        w_alu_b_sel = 1'b1;
      end
      7'b1100011: begin
        w_cls      = C_BRANCH;
        w_ext_op   = 3'b011;
        w_alu_func = {1'b0, w_funct3};
      end
      7'b1101111: begin
        w_cls    = C_JAL;
        w_ext_op = 3'b100;
        w_wb_sel = 2'b10;
      end
      7'b1100111: begin
        w_cls       = C_JALR;
        w_alu_b_sel = 1'b1;
        w_wb_sel    = 2'b10;
      end
      7'b0110111: begin
        w_cls       = C_LUI;
        w_ext_op    = 3'b001;
        w_alu_a_sel = 2'b10;
        w_alu_b_sel = 1'b1;
      end
      7'b0010111: begin
        w_cls       = C_AUIPC;
        w_ext_op    = 3'b001;
        w_alu_a_sel = 2'b01;
        w_alu_b_sel = 1'b1;
      end
      7'b1110011: begin
        if (EBREAK_EN && instr == 32'h0010_0073) w_cls = C_EBREAK;
      end
      default: w_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= S_FETCH;
      r_cls       <= C_OP;
      r_ext_op    <= 3'b000;
      r_alu_a_sel <= 2'b00;
      r_alu_b_sel <= 1'b0;
      r_alu_func  <= 4'b0000;
      r_wb_sel    <= 2'b00;
      r_illegal   <= 1'b0;
      r_halted    <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_cls == C_ILL) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_cls == C_EBREAK) begin
            r_halted    <= 1'b1;
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            r_state     <= S_HALT;
          end else begin
            r_cls       <= w_cls;
            r_ext_op    <= w_ext_op;
            r_alu_a_sel <= w_alu_a_sel;
            r_alu_b_sel <= w_alu_b_sel;
            r_alu_func  <= w_alu_func;
            r_wb_sel    <= w_wb_sel;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (r_cls)
            C_BRANCH: begin
              r_instr_cnt <= r_instr_cnt + CNT_W'(1);
              r_state     <= S_FETCH;
            end
            C_LOAD, C_STORE: r_state <= S_MEM;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_cls == C_STORE) begin
              r_instr_cnt <= r_instr_cnt + CNT_W'(1);
              r_state     <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
          r_state     <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated with rst so nothing fires in a reset cycle, including
  // an access that was in flight when reset arrived.
  logic w_fetch_done, w_exec_jump;
  assign w_fetch_done = (r_state == S_FETCH) && mem_ready;
  assign w_exec_jump  = (r_state == S_EXEC) &&
                        (r_cls == C_JAL || r_cls == C_JALR ||
                         (r_cls == C_BRANCH && br_taken));

  assign mem_req = !rst && (r_state == S_FETCH || r_state == S_MEM);
  assign mem_we  = !rst && (r_state == S_MEM) && (r_cls == C_STORE);
  assign ir_we   = !rst && w_fetch_done;
  assign pc_we   = !rst && (w_fetch_done || w_exec_jump);
  assign reg_we  = !rst && (r_state == S_WB) && w_rd_nz;

  // Outside a taken jump the PC source is PC+4, which is what FETCH needs.
  always_comb begin
    pc_sel = 2'b00;
    if (w_exec_jump) pc_sel = (r_cls == C_JALR) ? 2'b10 : 2'b01;
  end

  assign ext_op    = r_ext_op;
  assign alu_a_sel = r_alu_a_sel;
  assign alu_b_sel = r_alu_b_sel;
  assign alu_func  = r_alu_func;
  assign wb_sel    = r_wb_sel;
  assign illegal   = r_illegal;
  assign halted    = r_halted;
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later, well away from the rising edge.
//   Strobes are compared as one vector {mem_req, mem_we, ir_we, pc_we, reg_we}.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel;
  logic [2:0]  ext_op, state;
  logic        alu_b_sel, illegal, halted;
  logic [3:0]  alu_func;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .ext_op(ext_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_func(alu_func), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal(illegal), .halted(halted), .state(state),
    .instr_cnt(instr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Settle after the falling edge, then check state and the strobe vector.
  task automatic cyc(input string tag, input logic [2:0] st,
                     input logic [4:0] strb);
    #1;
    check({tag, "_state"}, {29'd0, state}, {29'd0, st});
    check({tag, "_strb"}, {27'd0, mem_req, mem_we, ir_we, pc_we, reg_we},
          {27'd0, strb});
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  localparam logic [4:0] ST_NONE  = 5'b00000;
  localparam logic [4:0] ST_FWAIT = 5'b10000;
  localparam logic [4:0] ST_FDONE = 5'b10110;
  localparam logic [4:0] ST_LOAD  = 5'b10000;
  localparam logic [4:0] ST_STORE = 5'b11000;
  localparam logic [4:0] ST_JUMP  = 5'b00010;
  localparam logic [4:0] ST_WB    = 5'b00001;

  // Zero-wait ALU-class instruction: F, D, E, WB; checks decoded fields in EXEC.
  task automatic run_alu(input string tag, input logic [31:0] ins,
                         input logic [2:0] e_ext, input logic [1:0] e_a,
                         input logic e_b, input logic [3:0] e_func);
    instr = ins; mem_ready = 1'b1;
    cyc({tag, "_f"}, 3'd0, ST_FDONE); nxt();
    cyc({tag, "_d"}, 3'd1, ST_NONE);  nxt();
    cyc({tag, "_e"}, 3'd2, ST_NONE);
    check({tag, "_ext"},  {29'd0, ext_op},    {29'd0, e_ext});
    check({tag, "_asel"}, {30'd0, alu_a_sel}, {30'd0, e_a});
    check({tag, "_bsel"}, {31'd0, alu_b_sel}, {31'd0, e_b});
    check({tag, "_func"}, {28'd0, alu_func},  {28'd0, e_func});
    nxt();
    cyc({tag, "_w"}, 3'd4, ST_WB);
    check({tag, "_wbsel"}, {30'd0, wb_sel}, 32'd0);
    nxt();
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; br_taken = 1'b0;

    // Reset cycle: mem_ready high must still not fire any strobe.
    nxt();
    cyc("rst", 3'd0, ST_NONE);
    check("rst_cnt",  instr_cnt, 32'd0);
    check("rst_flags", {30'd0, illegal, halted}, 32'd0);
    check("rst_ext",  {29'd0, ext_op}, 32'd0);
    check("rst_func", {28'd0, alu_func}, 32'd0);
    check("rst_sel",  {26'd0, pc_sel, alu_a_sel, wb_sel}, 32'd0);
    check("rst_bsel", {31'd0, alu_b_sel}, 32'd0);
    nxt();
    rst = 1'b0;

    // addi x1,x0,5
    run_alu("addi", 32'h0050_0093, 3'b000, 2'b00, 1'b1, 4'b0000);
    #1 check("addi_cnt", instr_cnt, 32'd1);

    // beq taken, then not taken
    instr = 32'h0020_8463; br_taken = 1'b1;
    cyc("bt_f", 3'd0, ST_FDONE); nxt();
    cyc("bt_d", 3'd1, ST_NONE);  nxt();
    cyc("bt_e", 3'd2, ST_JUMP);
    check("bt_psel", {30'd0, pc_sel}, 32'd1);
    check("bt_ext", {29'd0, ext_op}, 32'd3);
    nxt();
    br_taken = 1'b0;
    cyc("bn_f", 3'd0, ST_FDONE);
    check("bt_cnt", instr_cnt, 32'd2);
    nxt();
    cyc("bn_d", 3'd1, ST_NONE); br_taken = 1'b1; nxt();
    br_taken = 1'b0;  // sampled only in EXEC
    cyc("bn_e", 3'd2, ST_NONE);
    check("bn_psel", {30'd0, pc_sel}, 32'd0);
    nxt();
    #1 check("bn_cnt", instr_cnt, 32'd3);

    // lw x5,0(x1): 2 FETCH waits, 3 MEM waits, 10 cycles total
    instr = 32'h0000_A283; mem_ready = 1'b0;
    cyc("lw_f0", 3'd0, ST_FWAIT); nxt();
    cyc("lw_f1", 3'd0, ST_FWAIT); nxt();
    mem_ready = 1'b1;
    cyc("lw_f2", 3'd0, ST_FDONE); nxt();
    cyc("lw_d", 3'd1, ST_NONE);   nxt();
    cyc("lw_e", 3'd2, ST_NONE);   nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("lw_mw%0d", i), 3'd3, ST_LOAD); nxt();
    end
    mem_ready = 1'b1;
    cyc("lw_m", 3'd3, ST_LOAD); nxt();
    cyc("lw_w", 3'd4, ST_WB);
    check("lw_wbsel", {30'd0, wb_sel}, 32'd1);
    nxt();
    #1 check("lw_cnt", instr_cnt, 32'd4);

    // sw x2,4(x1)
    instr = 32'h0020_A223;
    cyc("sw_f", 3'd0, ST_FDONE); nxt();
    cyc("sw_d", 3'd1, ST_NONE);  nxt();
    cyc("sw_e", 3'd2, ST_NONE);
    check("sw_ext", {29'd0, ext_op}, 32'd2);
    nxt();
    cyc("sw_m", 3'd3, ST_STORE); nxt();
    cyc("sw_next", 3'd0, ST_FDONE);
    check("sw_cnt", instr_cnt, 32'd5);

    // jal x0,8
    instr = 32'h0080_006F;
    nxt();
    cyc("jal_d", 3'd1, ST_NONE); nxt();
    cyc("jal_e", 3'd2, ST_JUMP);
    check("jal_psel", {30'd0, pc_sel}, 32'd1);
    check("jal_ext", {29'd0, ext_op}, 32'd4);
    nxt();
    cyc("jal_w", 3'd4, ST_NONE);
    check("jal_wbsel", {30'd0, wb_sel}, 32'd2);
    nxt();

    // jalr x1,0(x2)
    instr = 32'h0001_00E7;
    cyc("jr_f", 3'd0, ST_FDONE);
    check("jal_cnt", instr_cnt, 32'd6);
    nxt();
    cyc("jr_d", 3'd1, ST_NONE); nxt();
    cyc("jr_e", 3'd2, ST_JUMP);
    check("jr_psel", {30'd0, pc_sel}, 32'd2);
    nxt();
    cyc("jr_w", 3'd4, ST_WB);
    check("jr_wbsel", {30'd0, wb_sel}, 32'd2);
    nxt();

    // sub, srai, lui
    run_alu("sub",  32'h4020_81B3, 3'b000, 2'b00, 1'b0, 4'b1000);
    run_alu("srai", 32'h4030_D093, 3'b000, 2'b00, 1'b1, 4'b1101);
    run_alu("lui",  32'h1234_50B7, 3'b001, 2'b10, 1'b1, 4'b0000);
    #1 check("alu_cnt", instr_cnt, 32'd10);

    // Unsupported opcode 7'b0001011 -> HALT, strobes dead for 20 cycles
    instr = 32'h0000_000B;
    cyc("ill_f", 3'd0, ST_FDONE); nxt();
    cyc("ill_d", 3'd1, ST_NONE);  nxt();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc($sformatf("halt%0d", i), 3'd5, ST_NONE); nxt();
    end
    #1;
    check("ill_flags", {30'd0, illegal, halted}, 32'd3);
    check("ill_cnt", instr_cnt, 32'd10);
    rst = 1'b1; mem_ready = 1'b1;
    cyc("ill_rst", 3'd5, ST_NONE);
    nxt();
    rst = 1'b0;

    // Back in FETCH with counters cleared; lw then reset mid-MEM
    instr = 32'h0000_A283;
    cyc("rec_f", 3'd0, ST_FDONE);
    check("rec_cnt", instr_cnt, 32'd0);
    check("rec_flags", {30'd0, illegal, halted}, 32'd0);
    nxt();
    cyc("rm_d", 3'd1, ST_NONE); nxt();
    cyc("rm_e", 3'd2, ST_NONE); nxt();
    mem_ready = 1'b0;
    cyc("rm_m", 3'd3, ST_LOAD); nxt();
    rst = 1'b1; mem_ready = 1'b1;
    cyc("rm_rst", 3'd3, ST_NONE); nxt();
    rst = 1'b0;
    cyc("rm_after", 3'd0, ST_FDONE);
    check("rm_cnt", instr_cnt, 32'd0);
    nxt();

    // EBREAK: clean halt with the feature, illegal without it
    instr = 32'h0010_0073;
    cyc("eb_d", 3'd1, ST_NONE); nxt();
    cyc("eb_h", 3'd5, ST_NONE);
`ifdef MCTRL_EBREAK_EN
    check("eb_flags", {30'd0, illegal, halted}, 32'd1);
    check("eb_cnt", instr_cnt, 32'd1);
`else
    check("eb_flags", {30'd0, illegal, halted}, 32'd3);
    check("eb_cnt", instr_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
